// File: rtl/matmul_scheduler.sv
// Round-robin arbiter that time-shares one 3x3 signed matrix multiplier between two
// requesters: fetches A/B operands, loads the multiplier, starts it, forwards results.
module matmul_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 63,
  localparam int ACC_WIDTH = 2*DATA_WIDTH+2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req,
  output logic [1:0]            gnt,
  output logic                  op_rd,
  output logic                  op_sel,
  output logic [3:0]            op_addr,
  input  logic [DATA_WIDTH-1:0] op_data0,
  input  logic [DATA_WIDTH-1:0] op_data1,
  output logic [DATA_WIDTH-1:0] mm_a_in,
  output logic [DATA_WIDTH-1:0] mm_b_in,
  output logic [3:0]            mm_a_addr,
  output logic [3:0]            mm_b_addr,
  output logic                  mm_a_wen,
  output logic                  mm_b_wen,
  output logic                  mm_start,
  input  logic [ACC_WIDTH-1:0]  mm_c_out,
  input  logic                  mm_c_valid,
  input  logic                  mm_done,
  input  logic [1:0]            mm_c_row,
  input  logic [1:0]            mm_c_col,
  output logic [ACC_WIDTH-1:0]  res_data,
  output logic [3:0]            res_idx,
  output logic [1:0]            res_valid,
  output logic [1:0]            cpl,
  output logic [1:0]            err,
  output logic                  busy
);

  localparam int TW = $clog2(TIMEOUT+1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_A, S_LOAD_B, S_START, S_WAIT, S_CPL
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           gnt_q, gnt_d;
  logic                 last_q, last_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [TW-1:0]        tmo_q, tmo_d;
  logic                 wen_a_q, wen_a_d;
  logic                 wen_b_q, wen_b_d;
  logic [3:0]           addr_q, addr_d;
  logic                 start_q, start_d;
  logic [ACC_WIDTH-1:0] res_data_q, res_data_d;
  logic [3:0]           res_idx_q, res_idx_d;
  logic [1:0]           res_valid_q, res_valid_d;
  logic [1:0]           err_q, err_d;

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    start_d     = 1'b0;
    res_data_d  = res_data_q;
    res_idx_d   = res_idx_q;
    res_valid_d = '0;
    err_d       = '0;

    op_rd   = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
    op_sel  = (state_q == S_LOAD_B);
    op_addr = op_rd ? cnt_q : '0;
    wen_a_d = op_rd & ~op_sel;
    wen_b_d = op_rd & op_sel;
    addr_d  = op_addr;

    case (state_q)
      S_IDLE: begin
        if (req != 2'b00) begin
          // last_q holds the index of the requester granted most recently
          if (req == 2'b11) gnt_d = last_q ? 2'b01 : 2'b10;
          else              gnt_d = req;
          last_d  = gnt_d[1];
          cnt_d   = '0;
          state_d = S_LOAD_A;
        end
      end
      S_LOAD_A: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd8) begin
          cnt_d   = '0;
          state_d = S_LOAD_B;
        end
      end
      S_LOAD_B: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd8) begin
          cnt_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        // start is registered so it lands the cycle after the final B write
        start_d = 1'b1;
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mm_c_valid) begin
          res_data_d  = mm_c_out;
          res_idx_d   = {2'b00, mm_c_row} * 4'd3 + {2'b00, mm_c_col};
          res_valid_d = gnt_q;
        end
        if (mm_done) begin
          state_d = S_CPL;
        end else if (tmo_q == TW'(TIMEOUT)) begin
          err_d   = gnt_q;
          gnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_CPL: begin
        gnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      gnt_q       <= '0;
      last_q      <= 1'b1;
      cnt_q       <= '0;
      tmo_q       <= '0;
      wen_a_q     <= 1'b0;
      wen_b_q     <= 1'b0;
      addr_q      <= '0;
      start_q     <= 1'b0;
      res_data_q  <= '0;
      res_idx_q   <= '0;
      res_valid_q <= '0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      wen_a_q     <= wen_a_d;
      wen_b_q     <= wen_b_d;
      addr_q      <= addr_d;
      start_q     <= start_d;
      res_data_q  <= res_data_d;
      res_idx_q   <= res_idx_d;
      res_valid_q <= res_valid_d;
      err_q       <= err_d;
    end
  end

  assign gnt       = gnt_q;
  assign mm_a_in   = gnt_q[0] ? op_data0 : (gnt_q[1] ? op_data1 : '0);
  assign mm_b_in   = mm_a_in;
  assign mm_a_addr = addr_q;
  assign mm_b_addr = addr_q;
  assign mm_a_wen  = wen_a_q;
  assign mm_b_wen  = wen_b_q;
  assign mm_start  = start_q;
  assign res_data  = res_data_q;
  assign res_idx   = res_idx_q;
  assign res_valid = res_valid_q;
  assign cpl       = (state_q == S_CPL) ? gnt_q : 2'b00;
  assign err       = err_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_matmul_scheduler.sv
// Bench for matmul_scheduler: requester operand stores, a behavioural 3x3 multiplier
// stub with the reference timing, and a reference product computed from the stores.
module tb_matmul_scheduler;
  localparam int DW  = 32;
  localparam int AW  = 2*DW+2;
  localparam int TMO = 63;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    req = 2'b00;
  logic [1:0]    gnt;
  logic          op_rd, op_sel;
  logic [3:0]    op_addr;
  logic [DW-1:0] op_data0 = '0, op_data1 = '0;
  logic [DW-1:0] mm_a_in, mm_b_in;
  logic [3:0]    mm_a_addr, mm_b_addr;
  logic          mm_a_wen, mm_b_wen, mm_start;
  logic [AW-1:0] mm_c_out = '0;
  logic          mm_c_valid = 1'b0, mm_done = 1'b0;
  logic [1:0]    mm_c_row = '0, mm_c_col = '0;
  logic [AW-1:0] res_data;
  logic [3:0]    res_idx;
  logic [1:0]    res_valid, cpl, err;
  logic          busy;

  matmul_scheduler #(.DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt),
    .op_rd(op_rd), .op_sel(op_sel), .op_addr(op_addr),
    .op_data0(op_data0), .op_data1(op_data1),
    .mm_a_in(mm_a_in), .mm_b_in(mm_b_in), .mm_a_addr(mm_a_addr), .mm_b_addr(mm_b_addr),
    .mm_a_wen(mm_a_wen), .mm_b_wen(mm_b_wen), .mm_start(mm_start),
    .mm_c_out(mm_c_out), .mm_c_valid(mm_c_valid), .mm_done(mm_done),
    .mm_c_row(mm_c_row), .mm_c_col(mm_c_col),
    .res_data(res_data), .res_idx(res_idx), .res_valid(res_valid),
    .cpl(cpl), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0, n_bad = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [159:0] all_out;
  assign all_out = {gnt, op_rd, op_sel, op_addr, mm_a_in, mm_b_in, mm_a_addr, mm_b_addr,
                    mm_a_wen, mm_b_wen, mm_start, res_data, res_idx, res_valid, cpl, err, busy};

  // Requester operand stores; non-granted requester drives junk
  logic signed [DW-1:0] stA [2][9];
  logic signed [DW-1:0] stB [2][9];

  always @(posedge clk) begin
    op_data0 <= (op_rd && gnt[0]) ? (op_sel ? stB[0][int'(op_addr)] : stA[0][int'(op_addr)]) : DW'($urandom);
    op_data1 <= (op_rd && gnt[1]) ? (op_sel ? stB[1][int'(op_addr)] : stA[1][int'(op_addr)]) : DW'($urandom);
  end

  // Multiplier stub: valid at start+6+5i, done at start+47 unless disabled
  logic signed [DW-1:0] sA [9];
  logic signed [DW-1:0] sB [9];
  logic signed [AW-1:0] sC [9];
  logic done_en = 1'b1;
  logic run = 1'b0;
  int   st = 0;
  int   nt;
  assign nt = mm_start ? 1 : (run ? st + 1 : 0);

  function automatic logic signed [AW-1:0] stub_elem(input int i);
    logic signed [AW-1:0] acc, x, y;
    acc = '0;
    for (int k = 0; k < 3; k++) begin
      x = sA[(i/3)*3+k];
      y = sB[k*3+(i%3)];
      acc = acc + x * y;
    end
    return acc;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run <= 1'b0; st <= 0; mm_c_valid <= 1'b0; mm_done <= 1'b0;
    end else begin
      if (mm_a_wen) sA[int'(mm_a_addr)] <= mm_a_in;
      if (mm_b_wen) sB[int'(mm_b_addr)] <= mm_b_in;
      if (mm_start) begin
        run <= 1'b1;
        for (int i = 0; i < 9; i++) sC[i] <= stub_elem(i);
      end
      st <= nt;
      mm_c_valid <= (nt >= 6) && (nt <= 46) && ((nt - 6) % 5 == 0);
      if ((nt >= 6) && (nt <= 46)) begin
        mm_c_out <= sC[(nt-6)/5];
        mm_c_row <= 2'(((nt-6)/5) / 3);
        mm_c_col <= 2'(((nt-6)/5) % 3);
      end
      mm_done <= done_en && (nt == 47);
      if (nt == 47 && done_en) run <= 1'b0;
    end
  end

  function automatic logic signed [AW-1:0] ref_elem(input int g, input int i);
    logic signed [AW-1:0] acc, x, y;
    acc = '0;
    for (int k = 0; k < 3; k++) begin
      x = stA[g][(i/3)*3+k];
      y = stB[g][k*3+(i%3)];
      acc = acc + x * y;
    end
    return acc;
  endfunction

  // Observations of one transaction, offsets relative to the first granted cycle
  int n_rd, f_rd, l_rd, n_aw, f_aw, l_aw, n_bw, f_bw, l_bw, n_start, k_start;
  int n_res, n_cpl, k_cpl, n_err, k_err, k_drop, gnt_bad, busy_bad;
  int res_k [16];
  int res_i [16];
  logic signed [AW-1:0] res_d [16];
  logic [1:0] res_v [16];
  logic [1:0] g_obs, v_cpl, v_err;
  int unsigned g_cyc;

  task automatic run_txn(input logic [1:0] r, input bit release_req);
    n_rd = 0; f_rd = -1; l_rd = -1; n_aw = 0; f_aw = -1; l_aw = -1; n_bw = 0; f_bw = -1; l_bw = -1;
    n_start = 0; k_start = -1; n_res = 0; n_cpl = 0; k_cpl = -1; n_err = 0; k_err = -1;
    k_drop = -1; gnt_bad = 0; busy_bad = 0; g_obs = 2'b00; v_cpl = 2'b00; v_err = 2'b00;
    req = r;
    for (int w = 0; w < 10; w++) begin
      @(negedge clk);
      if (gnt != 2'b00) begin g_obs = gnt; break; end
    end
    if (g_obs == 2'b00) return;
    g_cyc = cyc;
    for (int k = 0; k < 200; k++) begin
      if (k > 0) @(negedge clk);
      if (op_rd)    begin if (n_rd == 0) f_rd = k; l_rd = k; n_rd++; end
      if (mm_a_wen) begin if (n_aw == 0) f_aw = k; l_aw = k; n_aw++; end
      if (mm_b_wen) begin if (n_bw == 0) f_bw = k; l_bw = k; n_bw++; end
      if (mm_start) begin k_start = k; n_start++; end
      if (res_valid != 2'b00) begin
        if (n_res < 16) begin
          res_k[n_res] = k; res_i[n_res] = int'(res_idx);
          res_d[n_res] = res_data; res_v[n_res] = res_valid;
        end
        n_res++;
      end
      if (cpl != 2'b00) begin k_cpl = k; v_cpl = cpl; n_cpl++; end
      if (err != 2'b00) begin k_err = k; v_err = err; n_err++; end
      if ((cpl != 2'b00 || err != 2'b00) && release_req) req = 2'b00;
      if (gnt == 2'b00) begin
        k_drop = k;
        if (busy !== 1'b0) busy_bad++;
        break;
      end
      if (gnt != g_obs) gnt_bad++;
      if (busy !== 1'b1) busy_bad++;
    end
  endtask

  task automatic do_reset();
    req = 2'b00;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (all_out !== '0) begin n_bad++; $display("FAIL reset_outputs: got %h want 0", all_out); end
  endtask

  task automatic test_identity();
    for (int i = 0; i < 9; i++) begin
      stA[0][i] = (i % 4 == 0) ? 32'sd1 : 32'sd0;
      stB[0][i] = DW'(i + 1);
      stA[1][i] = DW'($urandom); stB[1][i] = DW'($urandom);
    end
    run_txn(2'b01, 1'b1);
    n_cmp++; if (g_obs !== 2'b01) begin n_bad++; $display("FAIL id_gnt: got %b want 01", g_obs); end
    n_cmp++; if (n_rd != 18 || f_rd != 0 || l_rd != 17) begin n_bad++; $display("FAIL id_op_rd: got n=%0d %0d..%0d want 18 0..17", n_rd, f_rd, l_rd); end
    n_cmp++; if (n_aw != 9 || f_aw != 1 || l_aw != 9) begin n_bad++; $display("FAIL id_a_wen: got n=%0d %0d..%0d want 9 1..9", n_aw, f_aw, l_aw); end
    n_cmp++; if (n_bw != 9 || f_bw != 10 || l_bw != 18) begin n_bad++; $display("FAIL id_b_wen: got n=%0d %0d..%0d want 9 10..18", n_bw, f_bw, l_bw); end
    n_cmp++; if (n_start != 1 || k_start != 19) begin n_bad++; $display("FAIL id_start: got n=%0d at %0d want 1 at 19", n_start, k_start); end
    n_cmp++; if (n_res != 9) begin n_bad++; $display("FAIL id_res_count: got %0d want 9", n_res); end
    for (int i = 0; i < 9 && i < n_res; i++) begin
      n_cmp++;
      if (res_d[i] !== AW'(i + 1) || res_i[i] != i || res_v[i] !== 2'b01 || res_k[i] != 26 + 5*i) begin
        n_bad++;
        $display("FAIL id_res%0d: got data=%0d idx=%0d v=%b at %0d want data=%0d idx=%0d v=01 at %0d",
                 i, res_d[i], res_i[i], res_v[i], res_k[i], i + 1, i, 26 + 5*i);
      end
    end
    n_cmp++; if (n_cpl != 1 || v_cpl !== 2'b01 || k_cpl != 67) begin n_bad++; $display("FAIL id_cpl: got n=%0d %b at %0d want 1 01 at 67", n_cpl, v_cpl, k_cpl); end
    n_cmp++; if (k_drop != 68 || gnt_bad != 0 || n_err != 0) begin n_bad++; $display("FAIL id_gnt_hold: got drop=%0d bad=%0d err=%0d want 68 0 0", k_drop, gnt_bad, n_err); end
    n_cmp++; if (busy_bad != 0) begin n_bad++; $display("FAIL id_busy: got %0d bad cycles want 0", busy_bad); end
  endtask

  task automatic test_neg();
    for (int i = 0; i < 9; i++) begin
      stA[1][i] = 32'sd2; stB[1][i] = -32'sd3;
      stA[0][i] = DW'($urandom); stB[0][i] = DW'($urandom);
    end
    run_txn(2'b10, 1'b1);
    n_cmp++; if (g_obs !== 2'b10) begin n_bad++; $display("FAIL neg_gnt: got %b want 10", g_obs); end
    n_cmp++; if (n_res != 9) begin n_bad++; $display("FAIL neg_res_count: got %0d want 9", n_res); end
    for (int i = 0; i < 9 && i < n_res; i++) begin
      n_cmp++;
      if (res_d[i] !== -AW'(18) || res_v[i] !== 2'b10 || res_i[i] != i) begin
        n_bad++;
        $display("FAIL neg_res%0d: got data=%0d v=%b idx=%0d want -18 10 %0d", i, res_d[i], res_v[i], res_i[i], i);
      end
    end
    n_cmp++; if (v_cpl !== 2'b10 || k_cpl != 67) begin n_bad++; $display("FAIL neg_cpl: got %b at %0d want 10 at 67", v_cpl, k_cpl); end
  endtask

  task automatic test_max();
    logic signed [AW-1:0] e;
    e = AW'(64'd2147483647) * AW'(64'd2147483647) * AW'(3);
    for (int i = 0; i < 9; i++) begin
      stA[0][i] = 32'h7FFF_FFFF; stB[0][i] = 32'h7FFF_FFFF;
    end
    run_txn(2'b01, 1'b1);
    n_cmp++; if (n_res != 9) begin n_bad++; $display("FAIL max_res_count: got %0d want 9", n_res); end
    for (int i = 0; i < 9 && i < n_res; i++) begin
      n_cmp++;
      if (res_d[i] !== e) begin n_bad++; $display("FAIL max_res%0d: got %0d want %0d", i, res_d[i], e); end
    end
  endtask

  task automatic test_round_robin();
    int unsigned g_prev;
    logic [1:0] want [3];
    want[0] = 2'b01; want[1] = 2'b10; want[2] = 2'b01;
    for (int i = 0; i < 9; i++) begin
      stA[0][i] = DW'($urandom); stB[0][i] = DW'($urandom);
      stA[1][i] = DW'($urandom); stB[1][i] = DW'($urandom);
    end
    do_reset();
    g_prev = 0;
    for (int t = 0; t < 3; t++) begin
      run_txn(2'b11, t == 2);
      n_cmp++; if (g_obs !== want[t]) begin n_bad++; $display("FAIL rr_gnt%0d: got %b want %b", t, g_obs, want[t]); end
      n_cmp++; if (v_cpl !== want[t] || n_res != 9 || res_v[0] !== want[t] || res_v[8] !== want[t]) begin
        n_bad++; $display("FAIL rr_owner%0d: got cpl=%b n=%0d v0=%b v8=%b want %b", t, v_cpl, n_res, res_v[0], res_v[8], want[t]);
      end
      for (int i = 0; i < 9 && i < n_res; i++) begin
        n_cmp++;
        if (res_d[i] !== ref_elem(want[t][1] ? 1 : 0, i)) begin
          n_bad++; $display("FAIL rr_res%0d_%0d: got %0d want %0d", t, i, res_d[i], ref_elem(want[t][1] ? 1 : 0, i));
        end
      end
      if (t > 0) begin
        n_cmp++; if (g_cyc - g_prev != 69) begin n_bad++; $display("FAIL rr_period%0d: got %0d want 69", t, g_cyc - g_prev); end
      end
      g_prev = g_cyc;
    end
  endtask

  task automatic test_timeout();
    done_en = 1'b0;
    run_txn(2'b01, 1'b1);
    n_cmp++; if (n_err != 1 || v_err !== 2'b01 || k_err - k_start != TMO + 1) begin
      n_bad++; $display("FAIL to_err: got n=%0d %b at start+%0d want 1 01 at start+%0d", n_err, v_err, k_err - k_start, TMO + 1);
    end
    n_cmp++; if (n_cpl != 0 || k_drop != k_err) begin n_bad++; $display("FAIL to_drop: got cpl=%0d drop=%0d want 0 %0d", n_cpl, k_drop, k_err); end
    done_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    bit seen;
    seen = 1'b0;
    req = 2'b01;
    for (int w = 0; w < 10; w++) begin
      @(negedge clk);
      if (gnt != 2'b00) begin seen = 1'b1; break; end
    end
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL mid_gnt: got 00 want 01"); end
    repeat (30) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (all_out !== '0) begin n_bad++; $display("FAIL mid_async_zero: got %h want 0", all_out); end
    req = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    run_txn(2'b11, 1'b1);
    n_cmp++; if (g_obs !== 2'b01 || n_err != 0 || v_cpl !== 2'b01) begin n_bad++; $display("FAIL mid_ptr_reset: got gnt=%b err=%0d cpl=%b want 01 0 01", g_obs, n_err, v_cpl); end
    run_txn(2'b10, 1'b1);
    n_cmp++; if (g_obs !== 2'b10 || v_cpl !== 2'b10) begin n_bad++; $display("FAIL mid_req10: got gnt=%b cpl=%b want 10 10", g_obs, v_cpl); end
  endtask

  task automatic test_random();
    logic mdl_last;
    logic [1:0] r, exp_g;
    do_reset();
    mdl_last = 1'b1;
    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < 9; i++) begin
        stA[0][i] = DW'($urandom); stB[0][i] = DW'($urandom);
        stA[1][i] = DW'($urandom); stB[1][i] = DW'($urandom);
      end
      r = 2'($urandom_range(1, 3));
      if (r == 2'b11) exp_g = mdl_last ? 2'b01 : 2'b10;
      else            exp_g = r;
      mdl_last = exp_g[1];
      run_txn(r, 1'b1);
      n_cmp++; if (g_obs !== exp_g || v_cpl !== exp_g || n_res != 9) begin
        n_bad++; $display("FAIL rnd_txn%0d: got gnt=%b cpl=%b n=%0d want %b %b 9", t, g_obs, v_cpl, n_res, exp_g, exp_g);
      end
      for (int i = 0; i < 9 && i < n_res; i++) begin
        n_cmp++;
        if (res_d[i] !== ref_elem(exp_g[1] ? 1 : 0, i) || res_i[i] != i || res_v[i] !== exp_g) begin
          n_bad++; $display("FAIL rnd_res%0d_%0d: got %0d idx=%0d v=%b want %0d idx=%0d v=%b",
                            t, i, res_d[i], res_i[i], res_v[i], ref_elem(exp_g[1] ? 1 : 0, i), i, exp_g);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_neg();
    test_max();
    test_round_robin();
    test_timeout();
    test_reset_mid();
    test_random();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
